// File: rtl/fetch_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_pkg : shared constants and queue entry type for the fetch stage
// Revision 1.0
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_DATA_W = 32;
  localparam int FETCH_ADDR_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = '0;
  localparam logic [FETCH_DATA_W-1:0] NOP              = '0;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instruction;
    logic [FETCH_ADDR_W-1:0] pc_plus_4;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_queue : synchronous FIFO holding prefetched instructions; flush wins
// Revision 1.0
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fq_entry_t,
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // a full queue may still accept a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      entries[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_unit : PC, synchronous-read instruction memory and prefetch queue
// Revision 1.0
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W     = FETCH_DATA_W,
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter int                IMEM_DEPTH = 256,
  parameter int                FQ_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_ready,
  input  logic              i_prog_mode,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instruction,
  output logic [ADDR_W-1:0] o_pc_plus_4,
  output logic [ADDR_W-1:0] o_pc
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FQ_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] pc_plus_4;
  } queue_entry_t;

  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [DATA_W-1:0] rdata;

  logic              redirect;
  logic              issue;
  logic [CNT_W:0]    occupancy;
  logic              fq_push;
  logic              fq_pop;
  logic              fq_full;
  logic [CNT_W-1:0]  fq_count;
  queue_entry_t      fq_in;
  queue_entry_t      fq_head;

  logic              unused_prog_addr_bits;
  assign unused_prog_addr_bits = &{1'b0, i_prog_addr[ADDR_W-1:IDX_W+2], i_prog_addr[1:0]};

  assign redirect  = i_prog_mode || i_branch_taken || i_jump;
  // slots already promised to an in-flight read count against the depth
  assign occupancy = {1'b0, fq_count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = i_enable && !redirect && !fq_full && (occupancy < DEPTH_LIMIT);

  assign fq_push   = inflight && !redirect;
  assign fq_pop    = o_valid && i_ready && !redirect;
  assign fq_in     = '{instruction: rdata, pc_plus_4: inflight_pc + ADDR_W'(4)};

  always_ff @(posedge i_clk) begin
    if (i_prog_mode && i_prog_we) begin
      imem[i_prog_addr[IDX_W+1:2]] <= i_prog_data;
    end
    if (issue) begin
      rdata <= imem[pc[IDX_W+1:2]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;

      if (i_prog_mode) begin
        pc <= RESET_PC;
      end else if (i_branch_taken) begin
        pc <= i_branch_target;
      end else if (i_jump) begin
        pc <= i_jump_target;
      end else if (issue) begin
        pc <= pc + ADDR_W'(4);
      end
    end
  end

  fetch_queue #(
    .entry_t (queue_entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (i_clk),
    .rst       (i_reset),
    .flush     (redirect),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (fq_pop),
    .head      (fq_head),
    .full      (fq_full),
    .count     (fq_count)
  );

  assign o_valid       = (fq_count != '0);
  assign o_instruction = o_valid ? fq_head.instruction : DATA_W'(NOP);
  assign o_pc_plus_4   = o_valid ? fq_head.pc_plus_4 : '0;
  assign o_pc          = pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        ready;
  logic        prog_mode;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pc_plus_4;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .IMEM_DEPTH (256),
    .FQ_DEPTH   (4),
    .RESET_PC   (32'h0)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_enable        (enable),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_ready         (ready),
    .i_prog_mode     (prog_mode),
    .i_prog_we       (prog_we),
    .i_prog_addr     (prog_addr),
    .i_prog_data     (prog_data),
    .o_valid         (valid),
    .o_instruction   (instruction),
    .o_pc_plus_4     (pc_plus_4),
    .o_pc            (pc)
  );

  // memory image loaded by the bench: words 0..63 and word 255
  function automatic logic [31:0] exp_word(input int idx);
    if (idx == 255) return 32'hDEAD_BEEF;
    if (idx < 64)   return 32'h11 * (idx + 1);
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc4);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
    chk({tag, "_instr"}, instruction, exp_instr);
    chk({tag, "_pc4"}, pc_plus_4, exp_pc4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; ready = 1'b0; prog_mode = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) step();

    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc4", pc_plus_4, 32'h0);
    chk("rst_pc", pc, 32'h0);

    // program the instruction memory
    reset = 1'b0; prog_mode = 1'b1; prog_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      prog_addr = 32'(i * 4); prog_data = exp_word(i); step();
    end
    prog_addr = 32'h3FC; prog_data = exp_word(255); step();
    prog_we = 1'b0;
    chk("prog_valid", {31'b0, valid}, 32'd0);
    chk("prog_pc", pc, 32'h0);

    // sequential fetch: first cycle with prog low issues, head valid in third
    prog_mode = 1'b0; enable = 1'b1; ready = 1'b1;
    step();
    chk("seq_c1_valid", {31'b0, valid}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk_head("seq", exp_word(i), 32'(4 * (i + 1)));
      if (i < 3) step();
    end

    // backpressure: refetch from 0 with decode stalled
    jump = 1'b1; jump_target = 32'h0; ready = 1'b0;
    step();
    jump = 1'b0;
    repeat (10) step();
    chk("bp_pc", pc, 32'h10);
    chk_head("bp_hold", exp_word(0), 32'h4);
    step();
    chk_head("bp_stable", exp_word(0), 32'h4);
    chk("bp_pc_hold", pc, 32'h10);
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk_head("bp_drain", exp_word(i), 32'(4 * (i + 1)));
      step();
    end

    // branch while full flushes queue and in-flight read
    ready = 1'b0;
    repeat (6) step();
    chk("bf_full_valid", {31'b0, valid}, 32'd1);
    branch_taken = 1'b1; branch_target = 32'h40; ready = 1'b1;
    step();
    branch_taken = 1'b0;
    chk("bf_n1_valid", {31'b0, valid}, 32'd0);
    step();
    chk("bf_n2_valid", {31'b0, valid}, 32'd0);
    step();
    chk_head("bf_n3", exp_word(16), 32'h44);
    step();
    chk_head("bf_n4", exp_word(17), 32'h48);

    // branch has priority over a simultaneous jump
    branch_taken = 1'b1; branch_target = 32'h80; jump = 1'b1; jump_target = 32'hC0;
    step();
    branch_taken = 1'b0; jump = 1'b0;
    chk("bj_pc", pc, 32'h80);
    step();
    step();
    chk_head("bj_head", exp_word(32), 32'h84);

    // reset with three queued entries and one read in flight
    ready = 1'b0; jump = 1'b1; jump_target = 32'h0;
    step();
    jump = 1'b0;
    repeat (4) step();
    chk_head("rm_pre", exp_word(0), 32'h4);
    reset = 1'b1;
    step();
    chk("rm_valid", {31'b0, valid}, 32'd0);
    chk("rm_pc", pc, 32'h0);
    chk("rm_instr", instruction, 32'h0);
    chk("rm_pc4", pc_plus_4, 32'h0);
    reset = 1'b0; ready = 1'b1;
    step();
    chk("rm_c1_valid", {31'b0, valid}, 32'd0);
    step();
    chk_head("rm_c2", exp_word(0), 32'h4);
    step();
    chk_head("rm_c3", exp_word(1), 32'h8);

    // index wrap past the last memory word
    branch_taken = 1'b1; branch_target = 32'h3FC;
    step();
    branch_taken = 1'b0;
    step();
    step();
    chk_head("wrap_255", exp_word(255), 32'h400);
    step();
    chk_head("wrap_0", exp_word(0), 32'h404);
    step();
    chk_head("wrap_1", exp_word(1), 32'h408);

    // disabled fetch still drains queued entries
    jump = 1'b1; jump_target = 32'h0; ready = 1'b0;
    step();
    jump = 1'b0;
    repeat (6) step();
    enable = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("dis_drain", exp_word(i), 32'(4 * (i + 1)));
      step();
    end
    chk("dis_empty", {31'b0, valid}, 32'd0);
    step();
    chk("dis_empty2", {31'b0, valid}, 32'd0);
    chk("dis_pc", pc, 32'h10);

    // programming mode mid-run behaves as a fetch reset
    enable = 1'b1;
    repeat (4) step();
    prog_mode = 1'b1;
    step();
    chk("pm_valid", {31'b0, valid}, 32'd0);
    chk("pm_pc", pc, 32'h0);
    prog_mode = 1'b0;
    step();
    step();
    chk_head("pm_resume", exp_word(0), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
